// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Read-side sequencer for the pipelined operand RAM. It accepts a burst
//   command (base, length) and drives the RAM read address at up to one read
//   per cycle. It tracks the fixed RAM read latency and returns the words as a
//   valid/ready stream through a small first-word-fall-through skid FIFO.
//   Reads are only issued while FIFO space is guaranteed, so downstream
//   backpressure can never drop a word.
//
// Build option:
//   RAM_STREAM_READER_WRAP_EN
//     defined   : the address wraps from DEPTH-1 to 0 and any length up to
//                 DEPTH is accepted. err is tied to 0.
//     undefined : a burst that would run past DEPTH-1 is rejected and err
//                 pulses for one cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/cmd_ready command handshake (ready only while idle)
//   cmd_base, cmd_len   first address and word count (0..DEPTH)
//   ram_addrb           registered RAM read address
//   ram_doutb           RAM read data, RD_LAT cycles after the address
//   out_valid/out_ready output stream handshake
//   out_data, out_last  head word of the FIFO and its end-of-burst flag
//   busy                high whenever a burst is active
//   err                 one-cycle pulse for a rejected command
module ram_stream_reader #(
    parameter int DATA_W     = 272,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 141,
    parameter int RD_LAT     = 3,
    parameter int FIFO_DEPTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_len,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    // One tracker stage per cycle from the address being on ram_addrb up to
    // the cycle its data is captured, so a read counts as in flight until
    // the moment it lands in the FIFO.
    localparam int TRK_N = RD_LAT + 1;
    localparam int INF_W = $clog2(TRK_N + 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   rem_q;
    logic [TRK_N-1:0]    vld_q;
    logic [TRK_N-1:0]    lst_q;
    logic [DATA_W:0]     fifo_mem [FIFO_DEPTH];   // {last, data}
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                cmd_fire, cmd_legal, start;
    logic                issue, issue_last, push, pop, credit_ok;
    logic [ADDR_W-1:0]   issue_addr;
    logic [INF_W-1:0]    inflight;
    logic [31:0]         occupancy;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
`ifdef RAM_STREAM_READER_WRAP_EN
        return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
`else
        return a + ADDR_W'(1);
`endif
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ---------------- command qualification ----------------
    assign cmd_fire = cmd_valid && (state_q == S_IDLE);

`ifdef RAM_STREAM_READER_WRAP_EN
    assign cmd_legal = ({1'b0, cmd_base} < DEPTH_L) && ({1'b0, cmd_len} <= DEPTH_L);
    assign err       = 1'b0;
`else
    logic [ADDR_W:0] cmd_end;
    logic            err_q;

    assign cmd_end   = {1'b0, cmd_base} + {1'b0, cmd_len};
    assign cmd_legal = ({1'b0, cmd_base} < DEPTH_L) && (cmd_end <= DEPTH_L);
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= cmd_fire && !cmd_legal;
    end
`endif

    // A legal nonzero command issues its first read on the accepting edge,
    // which puts the base address on ram_addrb in the following cycle.
    assign start = cmd_fire && cmd_legal && (cmd_len != '0);

    // ---------------- credit ----------------
    always_comb begin
        inflight = '0;
        for (int i = 0; i < TRK_N; i++) inflight = inflight + INF_W'(vld_q[i]);
    end

    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign push      = vld_q[TRK_N-1];

    // The slot freed by this cycle's pop is reusable; everything else is
    // counted from registered state, so the FIFO can never overflow.
    assign occupancy = 32'(cnt_q) + 32'(inflight) - {31'd0, pop};
    assign credit_ok = (occupancy < 32'(FIFO_DEPTH));

    assign issue      = start || ((state_q == S_ISSUE) && credit_ok);
    assign issue_addr = start ? cmd_base : addr_inc(addr_q);
    assign issue_last = start ? (cmd_len == ADDR_W'(1)) : (rem_q == ADDR_W'(1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (cmd_len == ADDR_W'(1)) ? S_DRAIN : S_ISSUE;
            S_ISSUE: if (issue && (rem_q == ADDR_W'(1))) state_d = S_DRAIN;
            S_DRAIN: if ((inflight == '0) && pop && out_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
    end

    // ---------------- address, length, latency tracker ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            rem_q  <= '0;
            vld_q  <= '0;
            lst_q  <= '0;
        end else begin
            if (issue) begin
                addr_q <= issue_addr;
                rem_q  <= (start ? cmd_len : rem_q) - ADDR_W'(1);
            end
            vld_q <= {vld_q[TRK_N-2:0], issue};
            lst_q <= {lst_q[TRK_N-2:0], issue && issue_last};
        end
    end

    assign ram_addrb = addr_q;

    // ---------------- skid FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {lst_q[TRK_N-1], ram_doutb};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Head entry is gated so the outputs read zero whenever the FIFO is empty.
    assign out_data = out_valid ? fifo_mem[rd_ptr_q][DATA_W-1:0] : '0;
    assign out_last = out_valid ? fifo_mem[rd_ptr_q][DATA_W]     : 1'b0;

endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;
    localparam int DATA_W = 272;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [7:0]        cmd_base = '0;
    logic [7:0]        cmd_len = '0;
    logic [7:0]        ram_addrb;
    logic [DATA_W-1:0] ram_doutb;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              err;

    ram_stream_reader dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // RAM model: ram[a] = a replicated across the word, 3-cycle read latency.
    logic [7:0] a1 = '0, a2 = '0, a3 = '0;
    always @(posedge clk) begin
        a1 <= ram_addrb;
        a2 <= a1;
        a3 <= a2;
    end
    assign ram_doutb = {34{a3}};

    function automatic logic [DATA_W-1:0] word_of(input logic [7:0] a);
        return {34{a}};
    endfunction

    // Monitor: records every accepted word and counts status cycles.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] got_data[$];
    logic              got_last[$];
    int                got_cyc[$];
    int                err_cnt = 0, busy_cnt = 0, vld_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                got_cyc.push_back(cyc);
                $display("[TB] cyc %0d pop data=%02h last=%0b", cyc, out_data[7:0], out_last);
            end
            if (err)       err_cnt  = err_cnt + 1;
            if (busy)      busy_cnt = busy_cnt + 1;
            if (out_valid) vld_cnt  = vld_cnt + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] b, input logic [7:0] l);
        cmd_base  = b;
        cmd_len   = l;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, DATA_W'(busy), '0);
    endtask

    initial begin
        int q0, p, errs, lasts;
        int e0, b0, v0;
        logic [7:0] a0;

        // ---------- reset ----------
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_cmd_ready", DATA_W'(cmd_ready), 1);
        check("rst_addr",      DATA_W'(ram_addrb), 0);
        check("rst_out_valid", DATA_W'(out_valid), 0);
        check("rst_out_data",  out_data,           0);
        check("rst_out_last",  DATA_W'(out_last),  0);
        check("rst_busy",      DATA_W'(busy),      0);
        check("rst_err",       DATA_W'(err),       0);
        tick();

        // ---------- basic burst base=10 len=4 ----------
        out_ready = 1'b1;
        send_cmd(8'd10, 8'd4);                           // cycle 1
        check("basic_addr_c1",  DATA_W'(ram_addrb), 10);
        check("basic_busy_c1",  DATA_W'(busy),      1);
        check("basic_ready_c1", DATA_W'(cmd_ready), 0);
        tick();                                          // cycle 2
        check("basic_addr_c2",  DATA_W'(ram_addrb), 11);
        tick(); tick();                                  // cycle 4
        check("basic_novalid_c4", DATA_W'(out_valid), 0);
        tick();                                          // cycle 5
        for (int k = 0; k < 4; k++) begin
            check($sformatf("basic_valid_%0d", k), DATA_W'(out_valid), 1);
            check($sformatf("basic_data_%0d", k),  out_data, word_of(8'(10 + k)));
            check($sformatf("basic_last_%0d", k),  DATA_W'(out_last), (k == 3) ? 1 : 0);
            tick();
        end                                              // cycle 9
        check("basic_busy_end",  DATA_W'(busy),      0);
        check("basic_ready_end", DATA_W'(cmd_ready), 1);
        check("basic_valid_end", DATA_W'(out_valid), 0);
        tick();

        // ---------- backpressure base=0 len=20 ----------
        q0 = got_data.size();
        send_cmd(8'd0, 8'd20);                           // cycle 1
        repeat (6) tick();                               // cycle 7
        out_ready = 1'b0;
        p = got_data.size() - q0;
        repeat (12) tick();
        // With the consumer stalled, exactly 5 words may be outstanding.
        check("bp_credit_addr", DATA_W'(ram_addrb), DATA_W'(p + 4));
        check("bp_valid_held",  DATA_W'(out_valid), 1);
        out_ready = 1'b1;
        wait_idle("bp", 200);
        check("bp_count", DATA_W'(got_data.size() - q0), 20);
        errs = 0;
        lasts = 0;
        for (int i = 0; i < 20 && (q0 + i) < got_data.size(); i++) begin
            if (got_data[q0 + i] !== word_of(8'(i))) errs++;
            if (got_last[q0 + i] !== (i == 19)) errs++;
        end
        check("bp_data_order", DATA_W'(errs), 0);
        tick();

        // ---------- full throughput base=0 len=141 ----------
        q0 = got_data.size();
        send_cmd(8'd0, 8'd141);
        wait_idle("full", 400);
        check("full_count", DATA_W'(got_data.size() - q0), 141);
        if (got_data.size() - q0 == 141) begin
            check("full_span", DATA_W'(got_cyc[q0 + 140] - got_cyc[q0]), 140);
            check("full_word140", got_data[q0 + 140], word_of(8'd140));
            check("full_last140", DATA_W'(got_last[q0 + 140]), 1);
        end
        errs = 0;
        lasts = 0;
        for (int i = 0; (q0 + i) < got_data.size(); i++) begin
            if (got_data[q0 + i] !== word_of(8'(i))) errs++;
            if (got_last[q0 + i]) lasts++;
        end
        check("full_data", DATA_W'(errs), 0);
        check("full_last_count", DATA_W'(lasts), 1);
        tick();

        // ---------- boundary base=139 len=4 ----------
        q0 = got_data.size();
        e0 = err_cnt;
        v0 = vld_cnt;
        a0 = ram_addrb;
`ifdef RAM_STREAM_READER_WRAP_EN
        send_cmd(8'd139, 8'd4);
        wait_idle("wrap", 100);
        check("wrap_count", DATA_W'(got_data.size() - q0), 4);
        if (got_data.size() - q0 == 4) begin
            check("wrap_d0", got_data[q0 + 0], word_of(8'd139));
            check("wrap_d1", got_data[q0 + 1], word_of(8'd140));
            check("wrap_d2", got_data[q0 + 2], word_of(8'd0));
            check("wrap_d3", got_data[q0 + 3], word_of(8'd1));
        end
        check("wrap_err_none", DATA_W'(err_cnt - e0), 0);
`else
        send_cmd(8'd139, 8'd4);                          // cycle 1
        check("rej_err_c1",   DATA_W'(err),       1);
        check("rej_busy_c1",  DATA_W'(busy),      0);
        check("rej_ready_c1", DATA_W'(cmd_ready), 1);
        tick();
        check("rej_err_c2",   DATA_W'(err),       0);
        repeat (10) tick();
        check("rej_err_pulses", DATA_W'(err_cnt - e0), 1);
        check("rej_no_valid",   DATA_W'(vld_cnt - v0), 0);
        check("rej_addr_hold",  DATA_W'(ram_addrb), DATA_W'(a0));
`endif
        tick();

        // ---------- zero length ----------
        a0 = ram_addrb;
        e0 = err_cnt;
        b0 = busy_cnt;
        v0 = vld_cnt;
        send_cmd(8'd50, 8'd0);
        check("zero_busy_c1",  DATA_W'(busy),      0);
        check("zero_ready_c1", DATA_W'(cmd_ready), 1);
        repeat (10) tick();
        check("zero_addr_hold", DATA_W'(ram_addrb), DATA_W'(a0));
        check("zero_busy_cnt",  DATA_W'(busy_cnt - b0), 0);
        check("zero_err_cnt",   DATA_W'(err_cnt - e0), 0);
        check("zero_vld_cnt",   DATA_W'(vld_cnt - v0), 0);

        // ---------- reset mid-burst ----------
        out_ready = 1'b0;
        send_cmd(8'd20, 8'd10);                          // cycle 1
        repeat (5) tick();                               // cycle 6: 2 buffered, 3 in flight
        check("mid_addr_c6",  DATA_W'(ram_addrb), 24);
        check("mid_valid_c6", DATA_W'(out_valid), 1);
        rst = 1'b1;
        tick();                                          // reset sampled
        rst = 1'b0;
        check("mid_valid_after_rst", DATA_W'(out_valid), 0);
        check("mid_ready_after_rst", DATA_W'(cmd_ready), 1);
        check("mid_busy_after_rst",  DATA_W'(busy),      0);
        out_ready = 1'b1;
        tick();
        q0 = got_data.size();
        send_cmd(8'd5, 8'd2);
        wait_idle("mid_new", 100);
        repeat (6) tick();
        check("mid_new_count", DATA_W'(got_data.size() - q0), 2);
        if (got_data.size() - q0 == 2) begin
            check("mid_new_d0", got_data[q0 + 0], word_of(8'd5));
            check("mid_new_d1", got_data[q0 + 1], word_of(8'd6));
            check("mid_new_l0", DATA_W'(got_last[q0 + 0]), 0);
            check("mid_new_l1", DATA_W'(got_last[q0 + 1]), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
